// File: rtl/dense_layer_fwd_if.sv
// Handshake/bus bundle for dense_layer_fwd.
// master = the surrounding datapath (producer/consumer, weight store),
// slave  = the layer engine itself.
interface dense_layer_fwd_if #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 5,
  parameter int DW    = 16
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                  start;
  logic                  act_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic [AW-1:0]         w_addr;
  logic [N_OUT*DW-1:0]   w_data;
  logic [N_OUT*DW-1:0]   bias;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_OUT*DW-1:0]   a_out;
  logic [N_OUT-1:0]      sat;
  logic                  busy;

  modport master (
    output start, act_sel, in_valid, in_data, w_data, bias, out_ready,
    input  in_ready, w_addr, out_valid, a_out, sat, busy
  );

  modport slave (
    input  start, act_sel, in_valid, in_data, w_data, bias, out_ready,
    output in_ready, w_addr, out_valid, a_out, sat, busy
  );
endinterface

// File: rtl/dense_layer_fwd.sv
// Generic fully-connected forward layer: streams N_IN activations, runs
// N_OUT parallel fixed-point MAC lanes against an external weight row,
// adds bias, applies ReLU or identity and saturates to DW bits.
// Optional macro LEAKY_RELU_EN: ReLU mode passes negative z as z>>>3
// instead of 0.
module dense_layer_fwd #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 5,
  parameter int DW    = 16,
  parameter int FRAC  = 10
) (
  input logic              clk,
  input logic              rst,   // asynchronous, active low
  dense_layer_fwd_if.slave bus
);

  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  // Headroom for N_IN full-scale products plus the shifted bias.
  localparam int ACC_W = 2*DW + $clog2(N_IN) + 1;

  localparam logic [AW-1:0] LAST_BEAT = AW'(N_IN - 1);

  localparam logic signed [ACC_W-1:0] Z_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Z_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]    D_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]    D_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_BIAS,
    S_ACT,
    S_HOLD
  } state_t;

  state_t                   state_q;
  logic [AW-1:0]            beat_q;
  logic                     act_sel_q;
  logic signed [ACC_W-1:0]  acc_q [N_OUT];
  logic [N_OUT*DW-1:0]      a_out_q;
  logic [N_OUT-1:0]         sat_q;
  logic                     out_valid_q;

  // Per-lane combinational terms feeding the single state register block.
  logic signed [ACC_W-1:0]  prod_ext [N_OUT];
  logic signed [ACC_W-1:0]  bias_ext [N_OUT];
  logic signed [DW-1:0]     act_d    [N_OUT];
  logic [N_OUT-1:0]         sat_d;

  logic signed [2*DW-1:0]   in_ext;
  assign in_ext = {{DW{bus.in_data[DW-1]}}, bus.in_data};

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
      logic signed [2*DW-1:0]  w_ext;
      logic signed [2*DW-1:0]  prod;
      logic signed [ACC_W-1:0] z_full;
      logic                    clip_hi;
      logic                    clip_lo;
      logic signed [DW-1:0]    z_c;
      logic signed [DW-1:0]    neg_v;

      assign w_ext = {{DW{bus.w_data[gi*DW+DW-1]}}, bus.w_data[gi*DW +: DW]};
      // Both operands already sign-extended, so the low 2*DW bits are exact.
      assign prod  = in_ext * w_ext;
      assign prod_ext[gi] = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
      assign bias_ext[gi] = {{(ACC_W-DW){bus.bias[gi*DW+DW-1]}}, bus.bias[gi*DW +: DW]} <<< FRAC;

      // Drop fraction (floor), then clip to the DW-bit signed range.
      assign z_full  = acc_q[gi] >>> FRAC;
      assign clip_hi = z_full > Z_MAX;
      assign clip_lo = z_full < Z_MIN;
      assign z_c     = clip_hi ? D_MAX : (clip_lo ? D_MIN : z_full[DW-1:0]);
      assign sat_d[gi] = clip_hi | clip_lo;

`ifdef LEAKY_RELU_EN
      assign neg_v = z_c >>> 3;
`else
      assign neg_v = '0;
`endif
      assign act_d[gi] = (!act_sel_q && z_c[DW-1]) ? neg_v : z_c;
    end
  endgenerate

  // Control FSM, beat counter, accumulators and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      act_sel_q   <= 1'b0;
      a_out_q     <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_ACC;
            beat_q    <= '0;
            act_sel_q <= bus.act_sel;
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
          end
        end
        S_ACC: begin
          if (bus.in_valid) begin
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= acc_q[j] + prod_ext[j];
            if (beat_q == LAST_BEAT) begin
              state_q <= S_BIAS;
              beat_q  <= '0;
            end else begin
              beat_q  <= beat_q + 1'b1;
            end
          end
        end
        S_BIAS: begin
          for (int j = 0; j < N_OUT; j++) acc_q[j] <= acc_q[j] + bias_ext[j];
          state_q <= S_ACT;
        end
        S_ACT: begin
          for (int j = 0; j < N_OUT; j++) a_out_q[j*DW +: DW] <= act_d[j];
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.w_addr    = beat_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_out_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_dense_layer_fwd.sv
// Self-checking bench for dense_layer_fwd: directed and random inferences
// compared against an arithmetic reference model of the layer.
module tb_dense_layer_fwd;

  localparam int N_IN  = 9;
  localparam int N_OUT = 5;
  localparam int DW    = 16;
  localparam int FRAC  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dense_layer_fwd_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus_if ();

  dense_layer_fwd #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int xv [N_IN];
  int wv [N_IN][N_OUT];
  int bv [N_OUT];
  int exp_a [N_OUT];
  int exp_s [N_OUT];
  int errors = 0;
  int checks = 0;

  logic [N_OUT*DW-1:0] wmem [N_IN];

  // External weight store addressed by the engine.
  always_comb begin
    bus_if.w_data = '0;
    if (int'(bus_if.w_addr) < N_IN) bus_if.w_data = wmem[bus_if.w_addr];
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: exact dot product + bias, floor-scale, clip, activate.
  function automatic void ref_model(input bit act);
    longint s, z, lim_hi, lim_lo;
    lim_hi = (64'sd1 <<< (DW-1)) - 1;
    lim_lo = -(64'sd1 <<< (DW-1));
    for (int j = 0; j < N_OUT; j++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(xv[i]) * longint'(wv[i][j]);
      s += longint'(bv[j]) * (64'sd1 <<< FRAC);
      z = floor_div(s, 64'sd1 <<< FRAC);
      exp_s[j] = 0;
      if (z > lim_hi) begin z = lim_hi; exp_s[j] = 1; end
      if (z < lim_lo) begin z = lim_lo; exp_s[j] = 1; end
      if (!act && z < 0) begin
`ifdef LEAKY_RELU_EN
        z = floor_div(z, 8);
`else
        z = 0;
`endif
      end
      exp_a[j] = int'(z);
    end
  endfunction

  task automatic load_vectors();
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++)
        wmem[i][j*DW +: DW] = DW'(wv[i][j]);
    for (int j = 0; j < N_OUT; j++) bus_if.bias[j*DW +: DW] = DW'(bv[j]);
  endtask

  task automatic fill(input int x, input int w, input int b);
    for (int i = 0; i < N_IN; i++) begin
      xv[i] = x;
      for (int j = 0; j < N_OUT; j++) wv[i][j] = w;
    end
    for (int j = 0; j < N_OUT; j++) bv[j] = b;
  endtask

  function automatic int rnd_range(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic check_outputs(input string tag);
    for (int j = 0; j < N_OUT; j++) begin
      check({tag, "_a_out"}, longint'($signed(bus_if.a_out[j*DW +: DW])), longint'(exp_a[j]));
      check({tag, "_sat"}, longint'(bus_if.sat[j]), longint'(exp_s[j]));
    end
  endtask

  task automatic do_start(input bit act);
    @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.act_sel = act;
    @(posedge clk);
    #1;
    bus_if.start   = 1'b0;
    bus_if.act_sel = ~act;  // must have been latched already
  endtask

  // One beat, preceded by random stall cycles; returns edges consumed.
  task automatic feed_beat(input int idx, input int stall_pct, output int edges);
    edges = 0;
    while (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct && edges < 20) begin
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = DW'($urandom);
      @(posedge clk);
      #1;
      edges++;
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = DW'(xv[idx]);
    @(negedge clk);
    check("w_addr", longint'(bus_if.w_addr), longint'(idx));
    @(posedge clk);
    #1;
    edges++;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = DW'($urandom);
  endtask

  task automatic run_inf(input string tag, input bit act, input int stall_pct,
                         input int hold_cycles, input bit check_lat);
    int edges, e, n;
    load_vectors();
    ref_model(act);
    do_start(act);
    edges = 1;
    for (int i = 0; i < N_IN; i++) begin
      feed_beat(i, stall_pct, e);
      edges += e;
    end
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (bus_if.out_valid === 1'b1) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_lat_beat"}, longint'(n), 2);
    if (check_lat) check({tag, "_lat_start"}, longint'(edges + n), longint'(N_IN + 3));
    check({tag, "_out_valid"}, longint'(bus_if.out_valid), 1);
    check_outputs(tag);
    $display("inference %s act=%0d lane0=%0d exp=%0d sat0=%0d latency=%0d",
             tag, act, $signed(bus_if.a_out[DW-1:0]), exp_a[0], bus_if.sat[0], n);
    // Backpressure: results must hold and start pulses must be ignored.
    bus_if.out_ready = 1'b0;
    for (int k = 0; k < hold_cycles; k++) begin
      bus_if.start = k[0];
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_hold_valid"}, longint'(bus_if.out_valid), 1);
      check({tag, "_hold_lane0"}, longint'($signed(bus_if.a_out[DW-1:0])), longint'(exp_a[0]));
      check({tag, "_hold_laneN"}, longint'($signed(bus_if.a_out[(N_OUT-1)*DW +: DW])),
            longint'(exp_a[N_OUT-1]));
    end
    bus_if.out_ready = 1'b1;
    bus_if.start     = (hold_cycles > 0);
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    bus_if.start     = 1'b0;
    check({tag, "_drain_valid"}, longint'(bus_if.out_valid), 0);
    check({tag, "_drain_busy"}, longint'(bus_if.busy), 0);
    if (hold_cycles > 0) begin
      @(posedge clk);
      #1;
      check({tag, "_start_ignored"}, longint'(bus_if.busy), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    bus_if.start     = 1'b0;
    bus_if.act_sel   = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    bus_if.bias      = '0;
    fill(0, 0, 0);
    load_vectors();

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(bus_if.in_ready), 0);
    check("rst_out_valid", longint'(bus_if.out_valid), 0);
    check("rst_busy", longint'(bus_if.busy), 0);
    check("rst_w_addr", longint'(bus_if.w_addr), 0);
    check("rst_a_out_lo", longint'(bus_if.a_out[DW-1:0]), 0);
    check("rst_sat", longint'(bus_if.sat), 0);
    rst = 1'b1;

    // Basic ReLU inference, latency checked
    fill(1024, 512, 0);
    run_inf("t1", 1'b0, 0, 0, 1'b1);

    // Negative weights: ReLU vs identity
    fill(1024, -512, 0);
    run_inf("t2_relu", 1'b0, 0, 0, 1'b1);
    run_inf("t2_ident", 1'b1, 0, 0, 1'b1);

    // Saturation at both rails
    fill(32767, 32767, 32767);
    run_inf("t3_pos", 1'b1, 0, 0, 1'b0);
    fill(32767, -32768, 32767);
    run_inf("t3_neg", 1'b1, 0, 0, 1'b0);
    run_inf("t3_neg_relu", 1'b0, 0, 0, 1'b0);

    // Bias only
    fill(0, 777, 0);
    bv[0] = 1024; bv[1] = -1024; bv[2] = 0; bv[3] = 5; bv[4] = -5;
    run_inf("t4_bias", 1'b1, 0, 0, 1'b0);

    // Input stalls and output backpressure with start pulses
    fill(1024, 512, 0);
    run_inf("t5_stall", 1'b0, 40, 6, 1'b0);

    // Asynchronous reset during accumulation, then a clean rerun
    fill(1024, 512, 0);
    load_vectors();
    do_start(1'b1);
    for (int i = 0; i < 4; i++) feed_beat(i, 0, e);
    bus_if.in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("t6_in_ready", longint'(bus_if.in_ready), 0);
    check("t6_out_valid", longint'(bus_if.out_valid), 0);
    check("t6_busy", longint'(bus_if.busy), 0);
    check("t6_w_addr", longint'(bus_if.w_addr), 0);
    check("t6_a_out_lo", longint'(bus_if.a_out[DW-1:0]), 0);
    check("t6_sat", longint'(bus_if.sat), 0);
    bus_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_inf("t6_rerun", 1'b0, 0, 0, 1'b1);

    // Random inferences: moderate range, then full range
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_IN; i++) begin
        xv[i] = (r < 3) ? rnd_range(-2048, 2047) : rnd_range(-32768, 32767);
        for (int j = 0; j < N_OUT; j++)
          wv[i][j] = (r < 3) ? rnd_range(-2048, 2047) : rnd_range(-32768, 32767);
      end
      for (int j = 0; j < N_OUT; j++) bv[j] = rnd_range(-32768, 32767);
      run_inf("rand", 1'($urandom_range(0, 1)), (r % 2) * 30, r % 3, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dense_layer_fwd.md
Name: dense_layer_fwd

Overview:
Parametrised, fully-connected forward-propagation layer for the DQN datapath. It replaces the fixed 9→5 and 5→4 hardwired layer logic with one generic engine. The engine streams N_IN activations, performs N_OUT parallel fixed-point MACs against an externally stored weight row, adds bias, applies the selected activation and saturates. Results are held under a valid/ready handshake. Instantiated once per layer (hidden: ReLU; output: identity for Q-values).

Parameters:
N_IN, 9, number of input activations per inference (≥1)
N_OUT, 5, number of neurons (parallel MAC lanes)
DW, 16, data/weight/bias width, signed two's complement
FRAC, 10, fractional bits (Q(DW-FRAC).FRAC); 1.0 = 2^FRAC

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin inference; accepted only in IDLE
act_sel  input  1  sampled at accepted start: 0 = ReLU, 1 = identity
in_valid  input  1  in_data valid
in_ready  output  1  engine accepts input this cycle
in_data  input  DW  input activation, signed
w_addr  output  clog2(N_IN) (min 1)  index of weight row for current beat
w_data  input  N_OUT*DW  weight row for w_addr; lane j at [j*DW +: DW]; must be valid in the same cycle as the beat
bias  input  N_OUT*DW  bias per lane; sampled in BIAS state
out_valid  output  1  results valid
out_ready  input  1  consumer accepts results
a_out  output  N_OUT*DW  activated results, lane j at [j*DW +: DW]
sat  output  N_OUT  per-lane saturation flag, valid with out_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ACC, BIAS, ACT, HOLD.
- IDLE:
  - start=1 → ACC.
  - Clears all accumulators and beat counter; latches act_sel.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: acc[j] += in_data * w_data lane j (full 2*DW product, sign-extended).
  - Beat counter increments on each beat; w_addr = beat counter.
  - in_valid=0 cycles are stalls: no accumulation, counter held.
  - After beat N_IN-1 is accepted → BIAS.
- BIAS:
  - in_ready=0.
  - acc[j] += sign-extended bias lane j << FRAC.
  - → ACT.
- ACT:
  - z[j] = acc[j] >>> FRAC (arithmetic shift, truncation toward −inf).
  - Clip z to [−2^(DW−1), 2^(DW−1)−1]; sat[j]=1 if clipped.
  - Activation: ReLU (act_sel=0) outputs 0 for z<0 after clipping; identity outputs the clipped z.
  - Register a_out/sat.
  - → HOLD.
- HOLD:
  - out_valid=1; a_out and sat stable.
  - out_valid&out_ready → IDLE.
  - A start asserted in the same cycle is ignored; a new start is required in IDLE.
- Accumulator width ACC_W = 2*DW + clog2(N_IN) + 1; no internal overflow is possible.
- Latency:
  - out_valid rises exactly 2 cycles after the clock edge that accepts the final beat.
  - Zero-stall inference: start → out_valid takes N_IN+3 cycles.
- start outside IDLE: ignored. in_valid outside ACC: ignored (in_ready=0).
- Reset (asynchronous, any state including mid-ACC):
  - State → IDLE.
  - in_ready=0, out_valid=0, busy=0, a_out=0, sat=0, w_addr=0.
  - Accumulators and counter cleared; latched act_sel cleared to 0.
  - A partial inference is discarded.
- a_out, sat and out_valid are registered outputs. in_ready, busy and w_addr are derived from registered state only (no combinational input→output path).

Optional Feature:
LEAKY_RELU_EN
- Defined: ReLU mode (act_sel=0) outputs z>>>3 (slope 1/8, arithmetic shift of the clipped z) for negative z instead of 0. The sat flag is unchanged.
- Undefined: standard ReLU, negative → 0.
- Identity mode is unaffected either way.

Test Plan:
1. Defaults, act_sel=0, 9 beats in_data=1024, all weights=512, bias=0 → each a_out lane=4608, sat=0; out_valid 2 cycles after 9th beat, 12 cycles after start.
2. Same stimulus with weights=−512:
   - act_sel=0 → all lanes 0.
   - act_sel=1 → all lanes −4608.
   - With LEAKY_RELU_EN and act_sel=0 → −576.
3. in_data=32767, weights=32767, bias=32767, act_sel=1 → all lanes 32767, sat=all ones.
   - Weights=−32768 → −32768, sat set.
   - Weights=−32768 with act_sel=0 → 0, sat set.
4. Bias-only check: inputs 0, bias lanes {1024, −1024, 0, 5, −5}, act_sel=1 → a_out equals bias exactly, sat=0.
5. Stall/backpressure:
   - Random in_valid gaps → results identical to test 1.
   - out_ready held low 6 cycles → a_out stable, out_valid high, start pulses ignored.
   - Single out_ready cycle → IDLE next cycle.
6. Reset mid-ACC: assert rst low after 4 beats → all outputs 0 immediately. Release and rerun test 1 → 4608 per lane, no residue from the aborted run.
